// File: rtl/skut_frame_arbiter.sv
// Round-robin write-port arbiter and ping-pong bank controller for the 2x128x8 SKUT frame RAM.
// Latency: req seen in IDLE -> RAM write strobe and ack one cycle later; a bank swap follows a strobe edge by 3+ cycles.
// Backpressure: 4-phase req/ack; a requester waits for ack, and bank swaps wait for the current handshake to finish.
module skut_frame_arbiter #(
    parameter int CHANNELS = 80
) (
    input  logic       iClk,
    input  logic       reset,
    input  logic       i8KHz,
    input  logic       iA_Req,
    input  logic [6:0] iA_Addr,
    input  logic [7:0] iA_Data,
    output logic       oA_Ack,
    input  logic       iB_Req,
    input  logic [6:0] iB_Addr,
    input  logic [7:0] iB_Data,
    output logic       oB_Ack,
    output logic       oRam_WrEn,
    output logic [7:0] oRam_Addr,
    output logic [7:0] oRam_Data,
    output logic       oRdBank,
    output logic       oFrameRdy,
    output logic [7:0] oWrCount,
    output logic       oAddrErr
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Widened to 8 bits so CHANNELS=128 still compares correctly against a 7-bit address.
    localparam logic [7:0] CH_LIMIT = 8'(CHANNELS);

    logic [1:0] s8k;
    logic       prev_8k;
    logic       swap_pend;
    logic [1:0] state;
    logic       grant;
    logic       last_grant;
    logic [6:0] lat_addr;
    logic [7:0] lat_data;
    logic [7:0] wr_cnt;

    logic frame_edge;
    logic swap_now;
    logic grant_a;
    logic addr_ok;
    logic granted_req;

    // Decode: frame edge, swap service slot, round-robin pick and address range.
    always_comb begin
        frame_edge  = s8k[1] & ~prev_8k;
        swap_now    = (state == ST_IDLE) & swap_pend;
        grant_a     = iA_Req & (~iB_Req | (last_grant == PORT_B));
        addr_ok     = ({1'b0, lat_addr} < CH_LIMIT);
        granted_req = (grant == PORT_B) ? iB_Req : iA_Req;
    end

    // Bring the asynchronous frame strobe into iClk and keep its previous value for edge detection.
    always_ff @(posedge iClk) begin
        if (!reset) begin
            s8k     <= 2'b00;
            prev_8k <= 1'b0;
        end else begin
            s8k     <= {s8k[0], i8KHz};
            prev_8k <= s8k[1];
        end
    end

    // Remember a frame edge until the FSM is idle; repeated edges collapse into one swap.
    always_ff @(posedge iClk) begin
        if (!reset) begin
            swap_pend <= 1'b0;
        end else begin
            swap_pend <= frame_edge | (swap_pend & ~swap_now);
        end
    end

    // Main handshake FSM: swap or grant in IDLE, write in WRITE, wait for req release in HOLD.
    always_ff @(posedge iClk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            grant      <= PORT_A;
            last_grant <= PORT_B;
            lat_addr   <= 7'd0;
            lat_data   <= 8'd0;
            wr_cnt     <= 8'd0;
            oA_Ack     <= 1'b0;
            oB_Ack     <= 1'b0;
            oRam_WrEn  <= 1'b0;
            oRam_Addr  <= 8'd0;
            oRam_Data  <= 8'd0;
            oRdBank    <= 1'b0;
            oFrameRdy  <= 1'b0;
            oWrCount   <= 8'd0;
            oAddrErr   <= 1'b0;
        end else begin
            oFrameRdy <= 1'b0;
            oRam_WrEn <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (swap_pend) begin
                        oRdBank   <= ~oRdBank;
                        oWrCount  <= wr_cnt;
                        wr_cnt    <= 8'd0;
                        oFrameRdy <= 1'b1;
                    end else if (iA_Req | iB_Req) begin
                        grant    <= grant_a ? PORT_A : PORT_B;
                        lat_addr <= grant_a ? iA_Addr : iB_Addr;
                        lat_data <= grant_a ? iA_Data : iB_Data;
                        state    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (addr_ok) begin
                        oRam_WrEn <= 1'b1;
                        oRam_Addr <= {~oRdBank, lat_addr};
                        oRam_Data <= lat_data;
                        if (wr_cnt != 8'hFF) begin
                            wr_cnt <= wr_cnt + 8'd1;
                        end
                    end else begin
                        oAddrErr <= 1'b1;
                    end
                    if (grant == PORT_B) begin
                        oB_Ack <= 1'b1;
                    end else begin
                        oA_Ack <= 1'b1;
                    end
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!granted_req) begin
                        oA_Ack     <= 1'b0;
                        oB_Ack     <= 1'b0;
                        last_grant <= grant;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skut_frame_arbiter.sv
// Testbench for skut_frame_arbiter: directed vector table, corner-case sequences, randomized two-port traffic.
// Inputs are driven on the falling edge and outputs sampled there, half a cycle after the active edge.
// Requesters follow the 4-phase protocol; every wait on the DUT is bounded.
module tb_skut_frame_arbiter;

    logic       iClk = 1'b0;
    logic       reset = 1'b0;
    logic       i8KHz = 1'b0;
    logic       iA_Req = 1'b0;
    logic [6:0] iA_Addr = 7'd0;
    logic [7:0] iA_Data = 8'd0;
    logic       iB_Req = 1'b0;
    logic [6:0] iB_Addr = 7'd0;
    logic [7:0] iB_Data = 8'd0;
    logic       oA_Ack, oB_Ack, oRam_WrEn, oRdBank, oFrameRdy, oAddrErr;
    logic [7:0] oRam_Addr, oRam_Data, oWrCount;

    skut_frame_arbiter #(.CHANNELS(80)) dut (
        .iClk(iClk), .reset(reset), .i8KHz(i8KHz),
        .iA_Req(iA_Req), .iA_Addr(iA_Addr), .iA_Data(iA_Data), .oA_Ack(oA_Ack),
        .iB_Req(iB_Req), .iB_Addr(iB_Addr), .iB_Data(iB_Data), .oB_Ack(oB_Ack),
        .oRam_WrEn(oRam_WrEn), .oRam_Addr(oRam_Addr), .oRam_Data(oRam_Data),
        .oRdBank(oRdBank), .oFrameRdy(oFrameRdy), .oWrCount(oWrCount), .oAddrErr(oAddrErr)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic       port;
        logic [6:0] addr;
        logic [7:0] data;
        logic       exp_wr;
        logic [7:0] exp_ram_addr;
        logic       exp_err;
    } vec_t;

    vec_t vecs[7];
    int   tests = 0;
    int   fails = 0;

    // Random-phase reference model state: each requester as a simple protocol agent.
    logic       rq[2];
    logic [6:0] ra[2];
    logic [7:0] rd[2];
    logic       prev_ack[2];
    logic       cur_ack[2];
    int         hold_cnt[2];
    int         idle_cnt[2];
    int         wait_cnt[2];
    int         model_valid = 0;
    int         obs_writes = 0;
    logic       model_err = 1'b0;
    int         overlap = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        @(negedge iClk);
    endtask

    task automatic set_port(input logic p, input logic r, input logic [6:0] a, input logic [7:0] d);
        if (!p) begin
            iA_Req = r; iA_Addr = a; iA_Data = d;
        end else begin
            iB_Req = r; iB_Addr = a; iB_Data = d;
        end
    endtask

    function automatic logic port_ack(input logic p);
        return p ? oB_Ack : oA_Ack;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        iA_Req = 1'b0;
        iB_Req = 1'b0;
        i8KHz = 1'b0;
        repeat (2) step();
        reset = 1'b1;
    endtask

    // One full handshake; reports any RAM write seen while waiting for ack.
    task automatic hs(input logic p, input logic [6:0] a, input logic [7:0] d,
                      output logic wr_seen, output logic [7:0] wr_addr);
        int n;
        wr_seen = 1'b0;
        wr_addr = 8'd0;
        set_port(p, 1'b1, a, d);
        n = 0;
        while (!port_ack(p) && n < 20) begin
            step();
            n++;
            if (oRam_WrEn) begin
                wr_seen = 1'b1;
                wr_addr = oRam_Addr;
            end
        end
        if (!port_ack(p)) begin
            tests++;
            fails++;
            $display("FAIL hs_ack_timeout: got no ack, expected ack within 20 cycles");
        end
        set_port(p, 1'b0, a, d);
        n = 0;
        while (port_ack(p) && n < 20) begin
            step();
            n++;
        end
    endtask

    // Directed single write with cycle-exact latency checks.
    task automatic apply_vec(input vec_t v, input int idx);
        set_port(v.port, 1'b1, v.addr, v.data);
        step();
        check($sformatf("v%0d_ack_at_grant", idx), port_ack(v.port), 0);
        step();
        check($sformatf("v%0d_ack", idx), port_ack(v.port), 1);
        check($sformatf("v%0d_other_ack", idx), port_ack(~v.port), 0);
        check($sformatf("v%0d_wren", idx), oRam_WrEn, v.exp_wr);
        if (v.exp_wr) begin
            check($sformatf("v%0d_ram_addr", idx), oRam_Addr, v.exp_ram_addr);
            check($sformatf("v%0d_ram_data", idx), oRam_Data, v.data);
        end
        step();
        check($sformatf("v%0d_wren_end", idx), oRam_WrEn, 0);
        repeat (2) step();
        check($sformatf("v%0d_ack_held", idx), port_ack(v.port), 1);
        set_port(v.port, 1'b0, v.addr, v.data);
        step();
        check($sformatf("v%0d_ack_release", idx), port_ack(v.port), 0);
        check($sformatf("v%0d_addr_err", idx), oAddrErr, v.exp_err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic       seen;
        logic [7:0] wa;
        int         n;
        logic       bad;
        string      order;

        vecs[0] = '{1'b0, 7'd5,   8'h7C, 1'b1, 8'h85, 1'b0};
        vecs[1] = '{1'b1, 7'd0,   8'h11, 1'b1, 8'h80, 1'b0};
        vecs[2] = '{1'b0, 7'd79,  8'hC3, 1'b1, 8'hCF, 1'b0};
        vecs[3] = '{1'b1, 7'd64,  8'h9E, 1'b1, 8'hC0, 1'b0};
        vecs[4] = '{1'b0, 7'd80,  8'h55, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{1'b1, 7'd127, 8'hAA, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{1'b0, 7'd3,   8'h01, 1'b1, 8'h83, 1'b1};

        // Reset values.
        repeat (3) step();
        check("reset_outputs",
              {oA_Ack, oB_Ack, oRam_WrEn, oRam_Addr, oRam_Data, oRdBank, oFrameRdy, oWrCount, oAddrErr}, 0);
        reset = 1'b1;
        step();

        // Directed vector table.
        for (int i = 0; i < 7; i++) begin
            apply_vec(vecs[i], i);
        end

        // Contention: both ports keep requesting, grants must alternate starting with A.
        do_reset();
        order = "";
        bad = 1'b0;
        set_port(1'b0, 1'b1, 7'd10, 8'hA0);
        set_port(1'b1, 1'b1, 7'd20, 8'hB0);
        prev_ack[0] = 1'b0;
        prev_ack[1] = 1'b0;
        n = 0;
        while (order.len() < 4 && n < 60) begin
            step();
            n++;
            if (oA_Ack && oB_Ack) bad = 1'b1;
            if (oA_Ack && !prev_ack[0]) begin order = {order, "A"}; iA_Req = 1'b0; end
            if (!oA_Ack && prev_ack[0]) iA_Req = 1'b1;
            if (oB_Ack && !prev_ack[1]) begin order = {order, "B"}; iB_Req = 1'b0; end
            if (!oB_Ack && prev_ack[1]) iB_Req = 1'b1;
            prev_ack[0] = oA_Ack;
            prev_ack[1] = oB_Ack;
        end
        tests++;
        if (order != "ABAB") begin
            fails++;
            $display("FAIL rr_order: got %s, expected ABAB", order);
        end
        check("rr_single_ack", bad, 0);
        iA_Req = 1'b0;
        iB_Req = 1'b0;
        repeat (4) step();

        // 80 writes then a frame strobe.
        do_reset();
        for (int i = 0; i < 80; i++) begin
            hs(1'b0, 7'(i), 8'(i ^ 8'h5A), seen, wa);
        end
        i8KHz = 1'b1;
        n = 0;
        while (!oFrameRdy && n < 12) begin
            step();
            n++;
        end
        check("swap_seen", oFrameRdy, 1);
        check("swap_latency_ge3", (n >= 3), 1);
        check("swap_rdbank", oRdBank, 1);
        check("swap_wrcount", oWrCount, 80);
        step();
        check("frame_rdy_one_cycle", oFrameRdy, 0);
        i8KHz = 1'b0;
        hs(1'b0, 7'd12, 8'h33, seen, wa);
        check("post_swap_bank", {seen, wa}, {1'b1, 8'h0C});

        // Frame strobe while port B sits in HOLD, with port A waiting.
        set_port(1'b1, 1'b1, 7'd7, 8'h44);
        n = 0;
        while (!oB_Ack && n < 20) begin
            step();
            n++;
        end
        check("hold_b_ack", oB_Ack, 1);
        i8KHz = 1'b1;
        set_port(1'b0, 1'b1, 7'd9, 8'h99);
        bad = 1'b0;
        repeat (10) begin
            step();
            if (oFrameRdy || !oB_Ack || oA_Ack) bad = 1'b1;
        end
        check("hold_no_swap", bad, 0);
        check("hold_rdbank_kept", oRdBank, 1);
        iB_Req = 1'b0;
        step();
        check("hold_b_released", oB_Ack, 0);
        check("hold_no_swap_yet", oFrameRdy, 0);
        step();
        check("hold_swap_first", {oFrameRdy, oRdBank, oA_Ack}, 3'b100);
        check("hold_wrcount", oWrCount, 2);
        step();
        check("hold_a_grant_pending", oA_Ack, 0);
        step();
        check("hold_a_write", {oA_Ack, oRam_WrEn, oRam_Addr, oRam_Data}, {1'b1, 1'b1, 8'h89, 8'h99});
        iA_Req = 1'b0;
        i8KHz = 1'b0;
        step();

        // Reset asserted while in WRITE.
        set_port(1'b0, 1'b1, 7'd3, 8'h05);
        step();
        reset = 1'b0;
        iA_Req = 1'b0;
        step();
        check("midreset_outputs",
              {oA_Ack, oB_Ack, oRam_WrEn, oRam_Addr, oRam_Data, oRdBank, oFrameRdy, oWrCount, oAddrErr}, 0);
        reset = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            step();
            if (oA_Ack || oB_Ack || oRam_WrEn) bad = 1'b1;
        end
        check("midreset_no_ghost", bad, 0);

        // Randomized traffic from both ports against the protocol-level model.
        do_reset();
        for (int p = 0; p < 2; p++) begin
            rq[p] = 1'b0; ra[p] = 7'd0; rd[p] = 8'd0; prev_ack[p] = 1'b0;
            hold_cnt[p] = 0; idle_cnt[p] = p; wait_cnt[p] = 0;
        end
        for (int cyc = 0; cyc < 6000; cyc++) begin
            step();
            cur_ack[0] = oA_Ack;
            cur_ack[1] = oB_Ack;
            if (cur_ack[0] && cur_ack[1]) overlap++;
            if (oRam_WrEn) obs_writes++;
            for (int p = 0; p < 2; p++) begin
                if (rq[p] && cur_ack[p] && !prev_ack[p]) begin
                    if (ra[p] < 7'd80) begin
                        model_valid++;
                        check($sformatf("rnd_write_p%0d", p), {oRam_WrEn, oRam_Addr, oRam_Data},
                              {1'b1, 1'b1, ra[p], rd[p]});
                    end else begin
                        model_err = 1'b1;
                        check($sformatf("rnd_no_write_p%0d", p), oRam_WrEn, 0);
                    end
                    check("rnd_addr_err", oAddrErr, model_err);
                    hold_cnt[p] = int'($urandom_range(0, 3));
                    wait_cnt[p] = 0;
                end else if (rq[p] && cur_ack[p]) begin
                    if (hold_cnt[p] == 0) rq[p] = 1'b0;
                    else hold_cnt[p]--;
                end else if (rq[p]) begin
                    wait_cnt[p]++;
                    if (wait_cnt[p] > 20) begin
                        tests++;
                        fails++;
                        $display("FAIL rnd_ack_timeout: port %0d got no ack, expected within 20 cycles", p);
                        rq[p] = 1'b0;
                        wait_cnt[p] = 0;
                    end
                end else if (!cur_ack[p]) begin
                    if (idle_cnt[p] > 0) begin
                        idle_cnt[p]--;
                    end else if (cyc < 3000) begin
                        rq[p] = 1'b1;
                        ra[p] = 7'($urandom_range(0, 99));
                        rd[p] = 8'($urandom);
                        idle_cnt[p] = int'($urandom_range(0, 4));
                    end
                end
                prev_ack[p] = cur_ack[p];
            end
            set_port(1'b0, rq[0], ra[0], rd[0]);
            set_port(1'b1, rq[1], ra[1], rd[1]);
            if (cyc >= 3000 && !rq[0] && !rq[1] && !oA_Ack && !oB_Ack) break;
        end
        check("rnd_no_overlap", overlap, 0);
        check("rnd_write_count", obs_writes, model_valid);
        check("rnd_err_final", oAddrErr, model_err);
        repeat (2) step();
        i8KHz = 1'b1;
        n = 0;
        while (!oFrameRdy && n < 12) begin
            step();
            n++;
        end
        check("rnd_swap_seen", oFrameRdy, 1);
        check("rnd_wrcount_sat", oWrCount, (model_valid > 255) ? 255 : model_valid);
        i8KHz = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/skut_frame_arbiter.md
# skut_frame_arbiter

Write-port arbiter and ping-pong bank controller for the 2×128×8 SKUT frame RAM. Two requesters, port A (SKUT frame former) and port B (LCC/LKF sensor feeder), share the single RAM write port through a 4-phase req/ack handshake. Arbitration is round-robin. On each rising edge of the 8 kHz frame strobe the block swaps the write and read banks. The downstream serialiser reads the bank selected by oRdBank; the block reports per-frame write counts and address errors.

## Interface
- CHANNELS, 80: number of valid channel addresses per bank (0..CHANNELS-1); max 128.
- iClk  in  1  system clock.
- reset  in  1  synchronous, active-low; sampled on posedge iClk.
- i8KHz  in  1  asynchronous 8 kHz frame strobe.
- iA_Req  in  1  port A write request (level, 4-phase).
- iA_Addr  in  7  port A channel address.
- iA_Data  in  8  port A data.
- oA_Ack  out  1  port A acknowledge.
- iB_Req, iB_Addr[6:0], iB_Data[7:0], oB_Ack: port B, identical semantics.
- oRam_WrEn  out  1  RAM write strobe, one cycle per accepted write.
- oRam_Addr  out  8  {write bank, channel address}.
- oRam_Data  out  8  RAM write data.
- oRdBank  out  1  bank currently owned by the reader; the write bank is always ~oRdBank.
- oFrameRdy  out  1  one-cycle pulse on each bank swap.
- oWrCount  out  8  number of writes performed into the bank just released to the reader; latched at swap.
- oAddrErr  out  1  sticky flag: a request with address ≥ CHANNELS was seen. Cleared only by reset.

## Operation
- i8KHz passes through a 2-flop synchroniser S8K[1:0] and a previous-value register. A frame edge is S8K[1]=1 while prev=0.
- A frame edge sets swapPend. swapPend is serviced only in IDLE and takes precedence over new grants.
- States:
  - IDLE
    - If swapPend: toggle oRdBank; oWrCount<=wrCnt; wrCnt<=0; oFrameRdy<=1; clear swapPend; stay in IDLE.
    - Otherwise, if any request is pending: grant one request, latch its addr/data, go to WRITE.
  - WRITE
    - If latched addr < CHANNELS: oRam_WrEn<=1, oRam_Addr<={~oRdBank, addr}, oRam_Data<=data, wrCnt+1 (saturating at 255).
    - Otherwise: no write, oAddrErr<=1.
    - In both cases assert the granted ack. Go to HOLD.
  - HOLD
    - oRam_WrEn<=0.
    - When the granted req=0: drop the ack, lastGrant<=granted port, go to IDLE.
- Round-robin:
  - When only one port requests, that port is granted.
  - When both request, the port that is not lastGrant is granted.
  - lastGrant resets to B, so A wins the first contention.
- The bank is sampled in WRITE. A swap never splits a write, because swaps only occur in IDLE.
- A frame edge arriving while swapPend is already set is absorbed: one swap is performed and the edge is not counted twice.

## Timing
- Reset values:
  - oA_Ack=0, oB_Ack=0, oRam_WrEn=0, oRam_Addr=0, oRam_Data=0
  - oRdBank=0, oFrameRdy=0, oWrCount=0, oAddrErr=0
  - state=IDLE, swapPend=0, wrCnt=0, lastGrant=B
  - The reset also clears the synchroniser.
- Reset asserted mid-operation aborts the transaction immediately. No write or ack follows.
- Request to write latency: req sampled high in IDLE at edge n; oRam_WrEn and ack are high after edge n+1. oRam_WrEn is low after edge n+2.
- Ack stays high until the requester drops req. Ack falls 1 cycle after req is sampled low.
- Minimum handshake: 3 cycles per write (IDLE, WRITE, HOLD), plus 1 IDLE cycle before the next grant.
- Swap latency: i8KHz rises, and oRdBank toggles and oFrameRdy pulses no earlier than the 3rd posedge after the rise, later if a transaction is in HOLD.
- oFrameRdy is high for exactly one cycle.
- Requesters must hold addr/data stable until ack. The block latches them at grant.

## Test plan
- Reset, then single port A write of addr 5, data 0x7C: oRam_WrEn for 1 cycle with oRam_Addr=0x85 (bank 1) and data 0x7C; oA_Ack stays high until iA_Req drops.
- iA_Req and iB_Req both held, 4 handshakes: grants alternate A, B, A, B. Exactly one ack is high at a time.
- 80 port A writes, then an i8KHz rising edge: oRdBank=1, 1-cycle oFrameRdy, oWrCount=80. The next write goes to oRam_Addr bit7=0.
- i8KHz rising edge while port B is in HOLD with iB_Req held 10 cycles: no swap until B releases, then the swap occurs in the first IDLE cycle before any new grant.
- Port A request with addr 80 (CHANNELS=80): ack asserted, no oRam_WrEn, oAddrErr=1 and remains 1 after later valid writes.
- reset low during WRITE: all outputs go to reset values on the next edge. No extra write or ack appears after reset is released without a request.
